instr_fetch_queue: RTL and testbench

//  Front-end fetch unit and instruction FIFO (IFQ) that feeds the dispatcher.
//  - Generates sequential fetch PCs and reads instruction memory (fixed 1-cycle read latency).
//  - Buffers {PC+4, instruction} pairs; the head is presented first-word-fall-through.
//  - Pops on dispatcher read enable; flushes and redirects on dispatcher jump/branch.

---
 rtl/instr_fetch_queue.sv | 109 ++++++++++
 tb/tb_instr_fetch_queue.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch unit with an in-order fetch queue feeding the dispatcher.
// Sequential PC generation, fixed 1-cycle imem latency, FWFT head, flush on redirect.
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 16,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_rd_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        dispatch_ren,
    input  logic        dispatch_jump_branch,
    input  logic [31:0] dispatch_jmp_branch_addr,
    output logic [31:0] ifetch_pc_plus_four,
    output logic [31:0] ifetch_instruction,
    output logic        ifetch_empty_flag,
    output logic        ifq_full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef struct packed {
        logic [31:0] pc_plus_four;
        logic [31:0] instruction;
    } ifq_entry_t;

    ifq_entry_t       mem [DEPTH];
    ifq_entry_t       head;
    logic [31:0]      fetch_pc;
    logic [31:0]      inflight_pc;
    logic             inflight_v;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] credit;
    logic             flush;
    logic             issue;
    logic             push;
    logic             pop;

    // Credit counts the outstanding read so a returning word always has a slot;
    // a same-cycle pop is deliberately not credited.
    assign flush  = dispatch_jump_branch;
    assign credit = count + CNT_W'(inflight_v);
    assign issue  = ~rst & ~flush & (credit < DEPTH_C);
    assign push   = inflight_v & ~flush;
    assign pop    = dispatch_ren & ~ifetch_empty_flag & ~flush;

    assign imem_rd_en = issue;
    assign imem_addr  = fetch_pc;

    // Fetch PC and the one outstanding imem read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight_pc <= '0;
            inflight_v  <= 1'b0;
        end else if (flush) begin
            fetch_pc    <= dispatch_jmp_branch_addr;
            inflight_v  <= 1'b0;
        end else if (issue) begin
            inflight_pc <= fetch_pc;
            inflight_v  <= 1'b1;
            fetch_pc    <= fetch_pc + 32'd4;
        end else begin
            inflight_v  <= 1'b0;
        end
    end

    // Queue pointers and occupancy; flush resets them to the empty state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage needs no reset: head outputs are masked while count is zero
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{pc_plus_four: inflight_pc + 32'd4, instruction: imem_rdata};
        end
    end

    assign head                = mem[rd_ptr];
    assign ifetch_empty_flag   = (count == '0);
    assign ifq_full            = (count == DEPTH_C);
    assign ifetch_pc_plus_four = ifetch_empty_flag ? 32'h0 : head.pc_plus_four;
    assign ifetch_instruction  = ifetch_empty_flag ? 32'h0 : head.instruction;

    push_into_full: assert property (@(posedge clk) disable iff (rst) !(push && ifq_full));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: expected head entries are queued by the
// stimulus process and popped/compared by a monitor on every dispatcher read.
module tb_instr_fetch_queue;

    localparam int unsigned DEPTH    = 16;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_rd_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        dispatch_ren = 1'b0;
    logic        dispatch_jump_branch = 1'b0;
    logic [31:0] dispatch_jmp_branch_addr = 32'h0;
    logic [31:0] ifetch_pc_plus_four;
    logic [31:0] ifetch_instruction;
    logic        ifetch_empty_flag;
    logic        ifq_full;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] ins;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;
    int   pops   = 0;

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .imem_rd_en               (imem_rd_en),
        .imem_addr                (imem_addr),
        .imem_rdata               (imem_rdata),
        .dispatch_ren             (dispatch_ren),
        .dispatch_jump_branch     (dispatch_jump_branch),
        .dispatch_jmp_branch_addr (dispatch_jmp_branch_addr),
        .ifetch_pc_plus_four      (ifetch_pc_plus_four),
        .ifetch_instruction       (ifetch_instruction),
        .ifetch_empty_flag        (ifetch_empty_flag),
        .ifq_full                 (ifq_full)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return 32'h100 + (a >> 2);
    endfunction

    // Instruction memory with 1-cycle read latency
    always @(posedge clk) imem_rdata <= imem_word(imem_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic load_sb(input logic [31:0] start);
        sb.delete();
        for (int i = 0; i < 5 * int'(DEPTH); i++)
            sb.push_back('{pc4: start + 32'(4 * (i + 1)), ins: imem_word(start + 32'(4 * i))});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pops(input int target, input int budget, input string name);
        int n = 0;
        while (pops < target && n < budget) begin
            step();
            n++;
        end
        check(name, 32'(pops >= target), 32'd1);
    endtask

    task automatic do_flush(input logic [31:0] tgt);
        dispatch_jump_branch     = 1'b1;
        dispatch_jmp_branch_addr = tgt;
        load_sb(tgt);
        #1;
        check("flush_no_issue", 32'(imem_rd_en), 32'd0);
        step();
        dispatch_jump_branch = 1'b0;
    endtask

    // Monitor: a head consumed on the coming edge must match the scoreboard front
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (ifq_full) check("full_blocks_issue", 32'(imem_rd_en), 32'd0);
            if (dispatch_ren && !dispatch_jump_branch && !ifetch_empty_flag) begin
                if (sb.size() == 0) begin
                    total++;
                    $display("FAIL sb_underflow: got head 0x%08h expected no entry", ifetch_pc_plus_four);
                end else begin
                    e = sb.pop_front();
                    check("head_pc4", ifetch_pc_plus_four, e.pc4);
                    check("head_instr", ifetch_instruction, e.ins);
                    pops++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int base;

        // Reset state
        #2;
        check("rst_empty", 32'(ifetch_empty_flag), 32'd1);
        check("rst_rd_en", 32'(imem_rd_en), 32'd0);
        check("rst_addr", imem_addr, RESET_PC);
        check("rst_pc4", ifetch_pc_plus_four, 32'h0);
        check("rst_instr", ifetch_instruction, 32'h0);
        check("rst_full", 32'(ifq_full), 32'd0);
        load_sb(RESET_PC);
        step();
        rst = 1'b0;
        #1;
        check("rel_rd_en", 32'(imem_rd_en), 32'd1);
        check("rel_addr", imem_addr, 32'h0);

        // Fill without pops
        n = 0;
        while (!ifq_full && n < 100) begin
            step();
            n++;
        end
        check("fill_full", 32'(ifq_full), 32'd1);
        check("fill_rd_en", 32'(imem_rd_en), 32'd0);
        check("fill_addr", imem_addr, 32'(DEPTH * 4));
        check("fill_head_pc4", ifetch_pc_plus_four, 32'h4);
        check("fill_head_instr", ifetch_instruction, 32'h100);

        // Streaming pops every cycle
        base = pops;
        dispatch_ren = 1'b1;
        wait_pops(base + 2 * int'(DEPTH), 400, "stream_progress");
        dispatch_ren = 1'b0;

        // Flush with exactly 5 entries queued
        do_flush(32'h1000);
        repeat (6) step();
        check("q5_empty", 32'(ifetch_empty_flag), 32'd0);
        check("q5_head_pc4", ifetch_pc_plus_four, 32'h1004);
        check("q5_head_instr", ifetch_instruction, 32'h500);
        do_flush(32'h200);
        #1;
        check("fl_empty", 32'(ifetch_empty_flag), 32'd1);
        check("fl_addr", imem_addr, 32'h200);
        check("fl_rd_en", 32'(imem_rd_en), 32'd1);
        step();
        check("fl_empty_1", 32'(ifetch_empty_flag), 32'd1);
        step();
        check("fl_empty_2", 32'(ifetch_empty_flag), 32'd0);
        check("fl_head_pc4", ifetch_pc_plus_four, 32'h204);
        check("fl_head_instr", ifetch_instruction, 32'h180);
        base = pops;
        dispatch_ren = 1'b1;
        wait_pops(base + 8, 100, "post_flush_stream");
        dispatch_ren = 1'b0;

        // Back-to-back flushes: latest target wins
        do_flush(32'h300);
        do_flush(32'h400);
        #1;
        check("b2b_addr", imem_addr, 32'h400);
        step();
        step();
        check("b2b_head_pc4", ifetch_pc_plus_four, 32'h404);
        check("b2b_head_instr", ifetch_instruction, 32'h200);

        // Pointer wrap with random pop gaps
        base = pops;
        n = 0;
        while (pops < base + 3 * int'(DEPTH) && n < 3000) begin
            dispatch_ren = ($urandom_range(0, 2) != 0);
            step();
            n++;
        end
        dispatch_ren = 1'b0;
        check("wrap_progress", 32'(pops >= base + 3 * int'(DEPTH)), 32'd1);

        // Async reset between edges while streaming
        dispatch_ren = 1'b1;
        repeat (3) step();
        #2;
        rst = 1'b1;
        #1;
        check("arst_empty", 32'(ifetch_empty_flag), 32'd1);
        check("arst_rd_en", 32'(imem_rd_en), 32'd0);
        check("arst_addr", imem_addr, RESET_PC);
        check("arst_pc4", ifetch_pc_plus_four, 32'h0);
        check("arst_instr", ifetch_instruction, 32'h0);
        check("arst_full", 32'(ifq_full), 32'd0);
        load_sb(RESET_PC);
        step();
        rst = 1'b0;
        #1;
        check("arst_rel_rd_en", 32'(imem_rd_en), 32'd1);
        check("arst_rel_addr", imem_addr, RESET_PC);
        base = pops;
        wait_pops(base + 2 * int'(DEPTH), 400, "arst_resume");
        dispatch_ren = 1'b0;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
